// File: rtl/pe_mac_acc.sv
// pe_mac_acc: signed multiply-accumulate processing element for one array cell.
// A stationary weight multiplies each valid activation. The product runs through
// a MUL_LAT-deep pipeline with its valid bit. In CHAIN mode it is added to the
// incoming psum. In ACC mode it is accumulated locally over a window of
// i_acc_len products. Every add either saturates or wraps, set by SATURATE.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_data/_val       activation sample; each valid issues one multiply
//   i_weight/_val     stationary weight load (bypassed into a same-cycle multiply)
//   i_psum            incoming psum, sampled when the product reaches the adder (CHAIN)
//   i_mode            0 = CHAIN, 1 = ACC; taken only while idle with no issue
//   i_acc_len         ACC window length, latched by the first product (0 acts as 1)
//   i_clear           synchronous flush of pipeline, window and accumulator
//   o_psum/_val       registered result and its one-cycle strobe
//   o_busy            work in flight or ACC window partially filled
//
// ACC window states:
//   state    | meaning
//   ST_IDLE  | no products accumulated; next product opens a window
//   ST_FILL  | window open, cnt_q products accumulated, waiting for len_q
module pe_mac_acc #(
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 8,
   parameter int PSUM_W   = 16,
   parameter int MUL_LAT  = 3,
   parameter int CNT_W    = 8,
   parameter int SATURATE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   i_data,
   input  logic                i_data_val,
   input  logic [WEIGHT_W-1:0] i_weight,
   input  logic                i_weight_val,
   input  logic [PSUM_W-1:0]   i_psum,
   input  logic                i_mode,
   input  logic [CNT_W-1:0]    i_acc_len,
   input  logic                i_clear,
   output logic [PSUM_W-1:0]   o_psum,
   output logic                o_psum_val,
   output logic                o_busy
);

   localparam int PROD_W = DATA_W + WEIGHT_W;

   typedef enum logic {ST_IDLE, ST_FILL} win_state_t;

   logic [WEIGHT_W-1:0] weight_q, weight_d, eff_weight;
   logic [PROD_W-1:0]   data_ext, wt_ext, prod_now;
   logic [PROD_W-1:0]   prod_q [MUL_LAT];
   logic [PROD_W-1:0]   prod_d [MUL_LAT];
   logic [MUL_LAT-1:0]  val_q, val_d;
   logic                mode_q, mode_d;
   win_state_t          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, len_q, len_d, len_eff, cnt_next;
   logic [PSUM_W-1:0]   acc_q, acc_d, psum_q, psum_d, acc_new;
   logic                psum_val_q, psum_val_d;
   logic [PSUM_W:0]     prod_ext, sum_chain, sum_acc;

   // The sum is one bit wider than the psum. The top two bits disagree exactly
   // when the result is out of range.
   function automatic logic [PSUM_W-1:0] sat_fn(input logic [PSUM_W:0] s);
      logic [PSUM_W-1:0] r;
      r = s[PSUM_W-1:0];
      if ((SATURATE != 0) && (s[PSUM_W] != s[PSUM_W-1])) begin
         r = s[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
      end
      return r;
   endfunction

   // A weight loaded in the same cycle as a sample is used by that sample.
   assign eff_weight = i_weight_val ? i_weight : weight_q;
   assign data_ext   = {{WEIGHT_W{i_data[DATA_W-1]}}, i_data};
   assign wt_ext     = {{DATA_W{eff_weight[WEIGHT_W-1]}}, eff_weight};
   assign prod_now   = data_ext * wt_ext;

   assign prod_ext  = {{(PSUM_W+1-PROD_W){prod_q[MUL_LAT-1][PROD_W-1]}}, prod_q[MUL_LAT-1]};
   assign sum_chain = {i_psum[PSUM_W-1], i_psum} + prod_ext;
   assign sum_acc   = (state_q == ST_IDLE) ? prod_ext : ({acc_q[PSUM_W-1], acc_q} + prod_ext);
   assign acc_new   = sat_fn(sum_acc);
   assign len_eff   = (state_q == ST_IDLE) ? ((i_acc_len == '0) ? CNT_W'(1) : i_acc_len) : len_q;
   assign cnt_next  = (state_q == ST_IDLE) ? CNT_W'(1) : (cnt_q + CNT_W'(1));

   assign o_busy     = (|val_q) || (cnt_q != '0);
   assign o_psum     = psum_q;
   assign o_psum_val = psum_val_q;

   always_comb begin
      weight_d   = eff_weight;
      prod_d     = prod_q;
      prod_d[0]  = prod_now;
      val_d      = val_q;
      val_d[0]   = i_data_val;
      mode_d     = mode_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      acc_d      = acc_q;
      psum_d     = psum_q;
      psum_val_d = 1'b0;

      for (int i = 1; i < MUL_LAT; i++) begin
         prod_d[i] = prod_q[i-1];
         val_d[i]  = val_q[i-1];
      end

      if (!o_busy && !i_data_val) begin
         mode_d = i_mode;
      end

      if (i_clear) begin
         val_d   = '0;
         cnt_d   = '0;
         acc_d   = '0;
         state_d = ST_IDLE;
      end else if (val_q[MUL_LAT-1]) begin
         if (!mode_q) begin
            psum_d     = sat_fn(sum_chain);
            psum_val_d = 1'b1;
         end else begin
            len_d = len_eff;
            if (cnt_next == len_eff) begin
               psum_d     = acc_new;
               psum_val_d = 1'b1;
               cnt_d      = '0;
               acc_d      = '0;
               state_d    = ST_IDLE;
            end else begin
               acc_d   = acc_new;
               cnt_d   = cnt_next;
               state_d = ST_FILL;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         weight_q   <= '0;
         for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
         val_q      <= '0;
         mode_q     <= 1'b0;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         len_q      <= '0;
         acc_q      <= '0;
         psum_q     <= '0;
         psum_val_q <= 1'b0;
      end else begin
         weight_q   <= weight_d;
         for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= prod_d[i];
         val_q      <= val_d;
         mode_q     <= mode_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         acc_q      <= acc_d;
         psum_q     <= psum_d;
         psum_val_q <= psum_val_d;
      end
   end

endmodule

// File: tb/tb_pe_mac_acc.sv
// Bench for pe_mac_acc. Two instances share all inputs, one saturating and one
// wrapping. Expected results are computed by an integer model when a sample is
// issued, queued with their due cycle, and compared when the strobe appears.
module tb_pe_mac_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  i_data;
   logic        i_data_val;
   logic [7:0]  i_weight;
   logic        i_weight_val;
   logic [15:0] i_psum;
   logic        i_mode;
   logic [7:0]  i_acc_len;
   logic        i_clear;
   logic [15:0] o_psum_s, o_psum_w;
   logic        o_psum_val_s, o_psum_val_w;
   logic        o_busy_s, o_busy_w;

   always #5 clk = ~clk;

   pe_mac_acc #(.DATA_W(8), .WEIGHT_W(8), .PSUM_W(16), .MUL_LAT(3), .CNT_W(8), .SATURATE(1)) dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_data_val(i_data_val),
      .i_weight(i_weight), .i_weight_val(i_weight_val), .i_psum(i_psum),
      .i_mode(i_mode), .i_acc_len(i_acc_len), .i_clear(i_clear),
      .o_psum(o_psum_s), .o_psum_val(o_psum_val_s), .o_busy(o_busy_s));

   pe_mac_acc #(.DATA_W(8), .WEIGHT_W(8), .PSUM_W(16), .MUL_LAT(3), .CNT_W(8), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .i_data(i_data), .i_data_val(i_data_val),
      .i_weight(i_weight), .i_weight_val(i_weight_val), .i_psum(i_psum),
      .i_mode(i_mode), .i_acc_len(i_acc_len), .i_clear(i_clear),
      .o_psum(o_psum_w), .o_psum_val(o_psum_val_w), .o_busy(o_busy_w));

   typedef struct {
      int due;
      int s;
      int w;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] psum_at[int];
   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int w_m = 0, mode_m = 0, cnt_m = 0, len_m = 0, acc_s = 0, acc_w = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int clamp16(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic int wrap16(input int x);
      logic [15:0] t;
      t = x[15:0];
      return int'($signed(t));
   endfunction

   // i_psum is scheduled to appear in the cycle its product reaches the adder.
   always @(negedge clk) i_psum = psum_at.exists(cyc) ? psum_at[cyc] : 16'h0000;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("val_sat", int'(o_psum_val_s), 1);
            chk("val_wrap", int'(o_psum_val_w), 1);
            chk("psum_sat", int'($signed(o_psum_s)), e.s);
            chk("psum_wrap", int'($signed(o_psum_w)), e.w);
         end else begin
            if (o_psum_val_s) chk("spurious_sat", int'(o_psum_val_s), 0);
            if (o_psum_val_w) chk("spurious_wrap", int'(o_psum_val_w), 0);
         end
      end
   end

   task automatic issue(input int d, input bit wl, input int w, input int ps);
      int prod;
      i_data       = d[7:0];
      i_data_val   = 1'b1;
      i_weight     = w[7:0];
      i_weight_val = wl;
      if (wl) w_m = w;
      prod = d * w_m;
      if (mode_m == 0) begin
         psum_at[cyc+3] = ps[15:0];
         exp_q.push_back('{due: cyc + 4, s: clamp16(ps + prod), w: wrap16(ps + prod)});
      end else begin
         if (cnt_m == 0) begin
            len_m = (i_acc_len == 8'd0) ? 1 : int'(i_acc_len);
            acc_s = prod;
            acc_w = prod;
         end else begin
            acc_s = clamp16(acc_s + prod);
            acc_w = wrap16(acc_w + prod);
         end
         cnt_m++;
         if (cnt_m == len_m) begin
            exp_q.push_back('{due: cyc + 4, s: acc_s, w: acc_w});
            cnt_m = 0;
         end
      end
      @(negedge clk);
      i_data_val   = 1'b0;
      i_weight_val = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((o_busy_s || exp_q.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("idle_timeout", 0, 1);
   endtask

   task automatic set_mode(input int m);
      wait_idle();
      i_mode = m[0];
      @(negedge clk);
      mode_m = m;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; i_data = '0; i_data_val = 1'b0; i_weight = '0; i_weight_val = 1'b0;
      i_mode = 1'b0; i_acc_len = 8'd1; i_clear = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_psum", int'(o_psum_s), 0);
      chk("rst_val", int'(o_psum_val_s), 0);
      chk("rst_busy", int'(o_busy_s), 0);
      rst = 1'b1;
      @(negedge clk);

      // CHAIN basic: 5*3 + 100
      issue(5, 1'b1, 3, 100);
      wait_idle();

      // Signed, weight loaded with the sample, then reused
      issue(-128, 1'b1, -2, -1);
      issue(7, 1'b0, 0, 0);
      wait_idle();

      // Random back-to-back CHAIN traffic, including saturating sums
      for (int k = 0; k < 16; k++) begin
         issue(int'($urandom_range(0, 255)) - 128, 1'(($urandom_range(0, 1))),
               int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 65535)) - 32768);
      end
      wait_idle();

      // ACC windows of 4, back-to-back
      i_acc_len = 8'd4;
      set_mode(1);
      issue(1, 1'b1, 2, 0); issue(2, 1'b0, 0, 0); issue(3, 1'b0, 0, 0); issue(4, 1'b0, 0, 0);
      issue(10, 1'b0, 0, 0); issue(10, 1'b0, 0, 0); issue(0, 1'b0, 0, 0); issue(0, 1'b0, 0, 0);
      wait_idle();

      // Length 0 acts as 1
      i_acc_len = 8'd0;
      issue(3, 1'b1, 1, 0); issue(-5, 1'b0, 0, 0);
      wait_idle();

      // Overflow: 3 * 127 * 127
      i_acc_len = 8'd3;
      issue(127, 1'b1, 127, 0); issue(127, 1'b0, 0, 0); issue(127, 1'b0, 0, 0);
      wait_idle();

      // Clear a partial window, then a fresh window
      i_acc_len = 8'd4;
      issue(9, 1'b1, 2, 0); issue(9, 1'b0, 0, 0);
      chk("busy_fill", int'(o_busy_s), 1);
      i_clear = 1'b1;
      cnt_m = 0;
      @(negedge clk);
      i_clear = 1'b0;
      chk("busy_clr", int'(o_busy_s), 0);
      idle(6);
      for (int k = 0; k < 4; k++) issue(1, (k == 0), 1, 0);
      wait_idle();

      // Async reset with three products in flight
      set_mode(0);
      issue(1, 1'b1, 1, 10); issue(2, 1'b0, 0, 20); issue(3, 1'b0, 0, 30);
      #2 rst = 1'b0;
      #1;
      chk("arst_psum_sat", int'(o_psum_s), 0);
      chk("arst_psum_wrap", int'(o_psum_w), 0);
      chk("arst_val", int'(o_psum_val_s), 0);
      chk("arst_busy", int'(o_busy_s), 0);
      exp_q.delete();
      psum_at.delete();
      w_m = 0; mode_m = 0; cnt_m = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      idle(8);

      // i_mode toggled while busy must not take effect
      i_acc_len = 8'd2;
      i_mode = 1'b1;
      issue(4, 1'b1, 5, 7);
      idle(2);
      chk("busy_mode", int'(o_busy_s), 1);
      i_mode = 1'b0;
      wait_idle();

      idle(3);
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
